// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 registered mux with fixed/round-robin selection.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } oreg_state_e;

endpackage

// File: rtl/mux_nx1_rr_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
// Built as rotate (so ptr lands at bit 0), priority-encode, un-rotate.
module rr_pick #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  logic [N-1:0]    rot;
  logic [SELW:0]   pos;
  logic [SELW-1:0] off;
  logic [SELW:0]   sum;

  // Rotate, priority-encode the lowest rotated bit, then map back to a channel index.
  always_comb begin
    rot     = '0;
    pos     = '0;
    off     = '0;
    sum     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (SELW+1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      rot[k] = req[pos[SELW-1:0]];
    end
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_vld = 1'b1;
        off     = SELW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    gnt_idx = sum[SELW-1:0];
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-channel registered mux with valid/ready on every port; fixed or round-robin pick.
//
//   state | meaning
//   ------+----------------------------------------------
//   EMPTY | output register holds nothing, out_valid=0
//   FULL  | output register holds a word, out_valid=1
//
// Single stage, no skid buffer: out_ready feeds in_ready combinationally.
module mux_nx1_rr #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  import mux_pkg::*;

  oreg_state_e     state_q, state_d;
  logic [SELW-1:0] ptr_q;
  logic            rr_vld;
  logic [SELW-1:0] rr_idx;
  logic            fix_vld;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;
  logic [W-1:0]    gnt_data;
  logic            load_en;
  logic            xfer;

  rr_pick #(.N(N)) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // Grant selection: fixed select (out-of-range sel never grants) or round-robin.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) fix_vld = in_valid[i];
    end
    if (mode == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end else begin
      gnt_vld = fix_vld;
      gnt_idx = sel;
    end
  end

  // Ready fan-out and granted data; rst_n gating keeps in_ready low during reset.
  always_comb begin
    load_en  = rst_n & ((state_q == EMPTY) | out_ready);
    xfer     = load_en & gnt_vld;
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) begin
        in_ready[i] = xfer;
        gnt_data    = in_data[i*W +: W];
      end
    end
  end

  // Output register occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy: load wins over drain so a simultaneous drain+load stays FULL.
  always_comb begin
    state_d = state_q;
    if (xfer)                                state_d = FULL;
    else if (state_q == FULL && out_ready)   state_d = EMPTY;
  end

  assign out_valid = (state_q == FULL);

  // Output word and source channel; held on drain and under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
    end else if (xfer) begin
      out_data <= gnt_data;
      out_ch   <= gnt_idx;
    end
  end

  // Round-robin pointer: moves past the winner, only on round-robin transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (xfer && mode == MODE_RR) begin
      ptr_q <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
    end
  end

endmodule
